// File: rtl/crc8_check_stream.sv
// Receive-side CRC-8 checker: strips the trailing CRC byte from each frame, forwards the payload
// with m_tlast moved onto the last payload byte, and reports pass/fail plus saturating counters.
module crc8_check_stream #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [7:0]       s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    output logic [7:0]       m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             crc_valid,
    output logic             crc_ok,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [7:0] crc_update(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] n;
        x    = crc ^ b;
        n[0] = x[2] ^ x[4] ^ x[5];
        n[1] = x[0] ^ x[3] ^ x[5] ^ x[6];
        n[2] = x[0] ^ x[1] ^ x[4] ^ x[6] ^ x[7];
        n[3] = x[0] ^ x[1] ^ x[4] ^ x[7];
        n[4] = x[0] ^ x[1] ^ x[4];
        n[5] = x[1] ^ x[2] ^ x[5];
        n[6] = x[0] ^ x[2] ^ x[3] ^ x[6];
        n[7] = x[1] ^ x[3] ^ x[4] ^ x[7];
        return n;
    endfunction

    logic [7:0]       crc_q, crc_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [7:0]       m_tdata_q, m_tdata_d;
    logic             m_tvalid_q, m_tvalid_d;
    logic             m_tlast_q, m_tlast_d;
    logic             crc_valid_q, crc_valid_d;
    logic             crc_ok_q, crc_ok_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       crc_next;
    logic             accept;

    always_comb begin
        s_tready     = !m_tvalid_q | m_tready;
        accept       = s_tvalid & s_tready;
        crc_next     = crc_update(crc_q, s_tdata);
        crc_d        = crc_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q;
        m_tlast_d    = m_tlast_q;
        crc_valid_d  = 1'b0;
        crc_ok_d     = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;

        if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end

        if (accept) begin
            // The held byte is the last payload byte exactly when the incoming byte is the CRC.
            if (hold_valid_q) begin
                m_tdata_d  = hold_q;
                m_tvalid_d = 1'b1;
                m_tlast_d  = s_tlast;
            end
            if (!s_tlast) begin
                hold_d       = s_tdata;
                hold_valid_d = 1'b1;
                crc_d        = crc_next;
            end else begin
                hold_valid_d = 1'b0;
                crc_d        = 8'h00;
                crc_valid_d  = 1'b1;
                crc_ok_d     = (crc_next == 8'h00);
                if (frame_cnt_q != {CNT_W{1'b1}}) begin
                    frame_cnt_d = frame_cnt_q + CNT_ONE;
                end
                if (crc_next != 8'h00 && err_cnt_q != {CNT_W{1'b1}}) begin
                    err_cnt_d = err_cnt_q + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_q        <= 8'h00;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            m_tdata_q    <= 8'h00;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            crc_valid_q  <= 1'b0;
            crc_ok_q     <= 1'b0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            crc_q        <= crc_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            crc_valid_q  <= crc_valid_d;
            crc_ok_q     <= crc_ok_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    assign crc_valid = crc_valid_q;
    assign crc_ok    = crc_ok_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_crc8_check_stream.sv
// Scoreboard bench for crc8_check_stream: directed frames push expected payload/status into
// queues, and a negedge monitor pops and compares on every output transfer and crc_valid pulse.
module tb_crc8_check_stream;

    logic        clock;
    logic        reset_n;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        crc_valid;
    logic        crc_ok;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    logic [7:0]  s2_tdata;
    logic        s2_tvalid;
    logic        s2_tready;
    logic        s2_tlast;
    logic [7:0]  m2_tdata;
    logic        m2_tvalid;
    logic        m2_tlast;
    logic        crc2_valid;
    logic        crc2_ok;
    logic [1:0]  frame2_cnt;
    logic [1:0]  err2_cnt;

    int checks = 0;
    int fails  = 0;
    int exp_frames = 0;
    int exp_errs   = 0;

    logic [8:0] q_out[$];
    logic       q_crc[$];
    logic [8:0] e_out;
    logic       e_crc;

    crc8_check_stream #(.CNT_W(16)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .crc_valid(crc_valid),
        .crc_ok   (crc_ok),
        .frame_cnt(frame_cnt),
        .err_cnt  (err_cnt)
    );

    crc8_check_stream #(.CNT_W(2)) dut_sat (
        .clock    (clock),
        .reset_n  (reset_n),
        .s_tdata  (s2_tdata),
        .s_tvalid (s2_tvalid),
        .s_tready (s2_tready),
        .s_tlast  (s2_tlast),
        .m_tdata  (m2_tdata),
        .m_tvalid (m2_tvalid),
        .m_tready (1'b1),
        .m_tlast  (m2_tlast),
        .crc_valid(crc2_valid),
        .crc_ok   (crc2_ok),
        .frame_cnt(frame2_cnt),
        .err_cnt  (err2_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: a transfer seen at negedge completes on the following posedge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (m_tvalid && m_tready) begin
                checks++;
                if (q_out.size() == 0) begin
                    fails++;
                    $display("FAIL out_unexpected: got last=%0b data=%02h, required no output",
                             m_tlast, m_tdata);
                end else begin
                    e_out = q_out.pop_front();
                    if ({m_tlast, m_tdata} !== e_out) begin
                        fails++;
                        $display("FAIL out_byte: got last=%0b data=%02h, required last=%0b data=%02h",
                                 m_tlast, m_tdata, e_out[8], e_out[7:0]);
                    end
                end
            end
            if (crc_valid) begin
                checks++;
                if (q_crc.size() == 0) begin
                    fails++;
                    $display("FAIL crc_unexpected: got crc_valid ok=%0b, required no pulse", crc_ok);
                end else begin
                    e_crc = q_crc.pop_front();
                    if (crc_ok !== e_crc) begin
                        fails++;
                        $display("FAIL crc_ok: got %0b, required %0b", crc_ok, e_crc);
                    end
                end
            end
        end
    end

    task automatic expect_out(input logic [7:0] d, input logic l);
        q_out.push_back({l, d});
    endtask

    task automatic expect_crc(input logic ok);
        q_crc.push_back(ok);
        exp_frames++;
        if (!ok) exp_errs++;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int  n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        while (!acc) begin
            @(negedge clock);
            acc = s_tready;
            @(posedge clock);
            #1;
            if (!acc) begin
                n++;
                if (n > 50) begin
                    checks++;
                    fails++;
                    $display("FAIL send_timeout: byte %02h not accepted in 50 cycles", d);
                    acc = 1'b1;
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_counters(input string name);
        idle(3);
        check({name, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
        check({name, "_err_cnt"}, 64'(err_cnt), 64'(exp_errs));
    endtask

    initial begin
        reset_n   = 1'b0;
        s_tdata   = 8'h00;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        m_tready  = 1'b1;
        s2_tdata  = 8'h00;
        s2_tvalid = 1'b0;
        s2_tlast  = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", 64'({m_tvalid, m_tdata, m_tlast, crc_valid, crc_ok}), 64'd0);
        check("reset_counters", 64'({frame_cnt, err_cnt}), 64'd0);
        check("reset_s_tready", 64'(s_tready), 64'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(1);

        // 1: single-byte payload
        expect_out(8'h01, 1'b1);
        expect_crc(1'b1);
        send(8'h01, 1'b0);
        send(8'h5E, 1'b1);
        check_counters("t1");

        // 2: good then bad CRC on the same payload
        expect_out(8'h01, 1'b0);
        expect_out(8'h01, 1'b1);
        expect_crc(1'b1);
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        send(8'h9A, 1'b1);
        expect_out(8'h01, 1'b0);
        expect_out(8'h01, 1'b1);
        expect_crc(1'b0);
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        send(8'h9B, 1'b1);
        check_counters("t2");

        // 3: zero-payload frames
        expect_crc(1'b1);
        send(8'h00, 1'b1);
        expect_crc(1'b0);
        send(8'h5A, 1'b1);
        check_counters("t3");

        // 4: back-pressure with input gaps
        expect_out(8'h01, 1'b0);
        expect_out(8'h01, 1'b1);
        expect_crc(1'b1);
        send(8'h01, 1'b0);
        idle(2);
        m_tready = 1'b0;
        send(8'h01, 1'b0);
        idle(1);
        @(negedge clock);
        check("t4_s_tready_stalled", 64'(s_tready), 64'd0);
        check("t4_m_tvalid_held", 64'({m_tvalid, m_tdata}), 64'h101);
        fork
            send(8'h9A, 1'b1);
            begin
                idle(3);
                m_tready = 1'b1;
            end
        join
        check_counters("t4");

        // 5: back-to-back frames
        expect_out(8'h00, 1'b1);
        expect_crc(1'b1);
        expect_out(8'h01, 1'b1);
        expect_crc(1'b1);
        send(8'h00, 1'b0);
        send(8'h00, 1'b1);
        send(8'h01, 1'b0);
        send(8'h5E, 1'b1);
        check_counters("t5");

        // 6: reset mid-frame discards held and queued bytes
        m_tready = 1'b0;
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        reset_n = 1'b0;
        @(negedge clock);
        check("t6_reset_outputs", 64'({m_tvalid, m_tdata, m_tlast, crc_valid, crc_ok}), 64'd0);
        check("t6_reset_counters", 64'({frame_cnt, err_cnt}), 64'd0);
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        m_tready = 1'b1;
        exp_frames = 0;
        exp_errs   = 0;
        idle(1);
        expect_out(8'h01, 1'b1);
        expect_crc(1'b1);
        send(8'h01, 1'b0);
        send(8'h5E, 1'b1);
        check_counters("t6");

        // Saturation on the 2-bit instance: five bad zero-payload frames
        s2_tdata  = 8'h5A;
        s2_tlast  = 1'b1;
        s2_tvalid = 1'b1;
        idle(5);
        s2_tvalid = 1'b0;
        s2_tlast  = 1'b0;
        idle(2);
        check("sat_err_cnt", 64'(err2_cnt), 64'd3);
        check("sat_frame_cnt", 64'(frame2_cnt), 64'd3);
        check("sat_no_payload", 64'(m2_tvalid), 64'd0);

        idle(3);
        check("scoreboard_out_drained", 64'(q_out.size()), 64'd0);
        check("scoreboard_crc_drained", 64'(q_crc.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
